// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared combinational ALU.
// One operation in flight at a time: grant (IDLE) -> execute (EXEC) -> hold result (RESP).
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [2:0]  req0_ctrl,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req1_ctrl,
  output logic        req1_ready,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        rdy0, rdy1, vld0, vld1;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    vld0    = 1'b0;
    vld1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the priority port wins; otherwise the lone requester.
          gnt_d   = (req0_valid && req1_valid) ? prio_q : req1_valid;
          prio_d  = ~gnt_d;
          a_d     = gnt_d ? req1_A    : req0_A;
          b_d     = gnt_d ? req1_B    : req0_B;
          ctrl_d  = gnt_d ? req1_ctrl : req0_ctrl;
          rdy0    = ~gnt_d;
          rdy1    = gnt_d;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        vld0 = ~gnt_q;
        vld1 = gnt_q;
        if (gnt_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake and ALU outputs are forced quiet while reset is held low.
  assign req0_ready  = reset & rdy0;
  assign req1_ready  = reset & rdy1;
  assign resp0_valid = reset & vld0;
  assign resp1_valid = reset & vld1;
  assign alu_A       = reset ? a_q    : '0;
  assign alu_B       = reset ? b_q    : '0;
  assign alu_ctrl    = reset ? ctrl_q : '0;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU hooked to the alu_* ports.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result, alu_A, alu_B, alu_result;
  logic        resp_zero, alu_zero;
  logic [2:0]  alu_ctrl;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B), .req0_ctrl(req0_ctrl), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B), .req1_ctrl(req1_ctrl), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU: and/or/add/sub, other codes yield 0.
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctrl)
      3'b000:  alu_result = alu_A & alu_B;
      3'b001:  alu_result = alu_A | alu_B;
      3'b010:  alu_result = alu_A + alu_B;
      3'b011:  alu_result = alu_A - alu_B;
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_A == alu_B);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_A = 32'd9; req0_B = 32'd9; req0_ctrl = 3'b010;
    req1_A = 32'd9; req1_B = 32'd9; req1_ctrl = 3'b010;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    cyc(); cyc(); #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_req0_ready got %b exp 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_req1_ready got %b exp 0", req1_ready); end
    n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valids got %b exp 00", {resp0_valid, resp1_valid}); end
    n_cmp++; if ({alu_A, alu_B, alu_ctrl} !== 67'h0) begin n_err++; $display("FAIL rst_alu got %h %h %b exp 0", alu_A, alu_B, alu_ctrl); end
    n_cmp++; if ({resp_result, resp_zero} !== 33'h0) begin n_err++; $display("FAIL rst_resp got %h %b exp 0", resp_result, resp_zero); end
  endtask

  task automatic test_tie();
    cyc();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_A = 32'd7; req0_B = 32'd7; req0_ctrl = 3'b011;
    req1_A = 32'd1; req1_B = 32'd2; req1_ctrl = 3'b001;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie_grant got %b exp 10", {req0_ready, req1_ready}); end
    cyc(); req0_valid = 1'b0; #1;
    n_cmp++; if ({alu_A, alu_B, alu_ctrl} !== {32'd7, 32'd7, 3'b011}) begin n_err++; $display("FAIL tie_exec0_alu got %h %h %b exp 7 7 011", alu_A, alu_B, alu_ctrl); end
    n_cmp++; if ({req1_ready, resp0_valid} !== 2'b00) begin n_err++; $display("FAIL tie_exec0_hs got %b exp 00", {req1_ready, resp0_valid}); end
    cyc(); resp0_ready = 1'b1; #1;
    n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b10) begin n_err++; $display("FAIL tie_resp0_valid got %b exp 10", {resp0_valid, resp1_valid}); end
    n_cmp++; if ({resp_result, resp_zero} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL tie_resp0_data got %h %b exp 0 1", resp_result, resp_zero); end
    cyc(); resp0_ready = 1'b0; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL tie_grant1 got %b exp 01", {req0_ready, req1_ready}); end
    cyc(); req1_valid = 1'b0; #1;
    n_cmp++; if ({alu_A, alu_B, alu_ctrl} !== {32'd1, 32'd2, 3'b001}) begin n_err++; $display("FAIL tie_exec1_alu got %h %h %b exp 1 2 001", alu_A, alu_B, alu_ctrl); end
    cyc(); resp1_ready = 1'b1; #1;
    n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b01) begin n_err++; $display("FAIL tie_resp1_valid got %b exp 01", {resp0_valid, resp1_valid}); end
    n_cmp++; if ({resp_result, resp_zero} !== {32'd3, 1'b0}) begin n_err++; $display("FAIL tie_resp1_data got %h %b exp 3 0", resp_result, resp_zero); end
    cyc(); resp1_ready = 1'b0; #1;
    n_cmp++; if (resp1_valid !== 1'b0) begin n_err++; $display("FAIL tie_done got %b exp 0", resp1_valid); end
  endtask

  task automatic test_back_pressure();
    req1_valid = 1'b1; req1_A = 32'd10; req1_B = 32'd4; req1_ctrl = 3'b011; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_grant1 got %b exp 01", {req0_ready, req1_ready}); end
    cyc(); req1_valid = 1'b0;
    req0_valid = 1'b1; req0_A = 32'd3; req0_B = 32'd3; req0_ctrl = 3'b000; #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_exec_req0_ready got %b exp 0", req0_ready); end
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      n_cmp++; if ({resp1_valid, req0_ready, resp_result} !== {1'b1, 1'b0, 32'd6}) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b r0=%b res=%h exp v=1 r0=0 res=6", i, resp1_valid, req0_ready, resp_result);
      end
    end
    resp1_ready = 1'b1; #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs_req0_ready got %b exp 0", req0_ready); end
    cyc(); resp1_ready = 1'b0; #1;
    n_cmp++; if ({req0_ready, resp1_valid} !== 2'b10) begin n_err++; $display("FAIL bp_after_hs got %b exp 10", {req0_ready, resp1_valid}); end
    cyc(); req0_valid = 1'b0;
    cyc(); #1;
    n_cmp++; if ({resp0_valid, resp_result, resp_zero} !== {1'b1, 32'd3, 1'b1}) begin n_err++; $display("FAIL bp_resp0 got %b %h %b exp 1 3 1", resp0_valid, resp_result, resp_zero); end
  endtask

  task automatic test_wrong_port_ready();
    resp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b10) begin n_err++; $display("FAIL wrong_port[%0d] got %b exp 10", i, {resp0_valid, resp1_valid}); end
    end
    resp1_ready = 1'b0; resp0_ready = 1'b1;
    cyc(); resp0_ready = 1'b0; #1;
    n_cmp++; if (resp0_valid !== 1'b0) begin n_err++; $display("FAIL wrong_port_done got %b exp 0", resp0_valid); end
  endtask

  task automatic test_mid_reset_and_opcode();
    req0_valid = 1'b1; req0_A = 32'hFFFF_FFFF; req0_B = 32'hFFFF_FFFF; req0_ctrl = 3'b110;
    req1_valid = 1'b1; req1_A = 32'd1; req1_B = 32'd1; req1_ctrl = 3'b010; #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL rr_tie_prio1 got %b exp 01", {req0_ready, req1_ready}); end
    cyc(); reset = 1'b0; #1;
    n_cmp++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, alu_A} !== 36'h0) begin
      n_err++; $display("FAIL midrst_outputs got %b%b%b%b %h exp all 0", req0_ready, req1_ready, resp0_valid, resp1_valid, alu_A);
    end
    cyc(); reset = 1'b1; #1;
    n_cmp++; if ({resp_result, resp_zero, resp0_valid, resp1_valid} !== 35'h0) begin n_err++; $display("FAIL midrst_resp got %h %b %b %b exp 0", resp_result, resp_zero, resp0_valid, resp1_valid); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL midrst_prio got %b exp 10", {req0_ready, req1_ready}); end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    n_cmp++; if ({alu_ctrl, alu_A, alu_B} !== {3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL opc_alu got %b %h %h exp 110 ffffffff ffffffff", alu_ctrl, alu_A, alu_B); end
    cyc(); resp0_ready = 1'b1; #1;
    n_cmp++; if ({resp0_valid, resp_result, resp_zero} !== {1'b1, 32'd0, 1'b1}) begin n_err++; $display("FAIL opc_resp got %b %h %b exp 1 0 1", resp0_valid, resp_result, resp_zero); end
    cyc(); resp0_ready = 1'b0; #1;
    n_cmp++; if (resp0_valid !== 1'b0) begin n_err++; $display("FAIL opc_done got %b exp 0", resp0_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_back_pressure();
    test_wrong_port_ready();
    test_mid_reset_and_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, port that holds priority after reset (0 or 1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 req0_valid / req1_valid  in  1  requester has an operation pending.
REQ-005 req0_A, req0_B / req1_A, req1_B  in  32  operands.
REQ-006 req0_ctrl / req1_ctrl  in  3  ALU operation code, passed through unmodified.
REQ-007 req0_ready / req1_ready  out  1  request accepted this cycle.
REQ-008 resp0_valid / resp1_valid  out  1  result available to that requester.
REQ-009 resp0_ready / resp1_ready  in  1  requester consumes result.
REQ-010 resp_result  out  32  held ALU result, shared by both ports.
REQ-011 resp_zero  out  1  held ALU equality flag.
REQ-012 alu_A, alu_B  out  32  operands to the shared ALU.
REQ-013 alu_ctrl  out  3  operation code to the shared ALU.
REQ-014 alu_result  in  32  combinational ALU result.
REQ-015 alu_zero  in  1  combinational ALU flag (A==B).

Function
REQ-016 FSM states SHALL be IDLE, EXEC and RESP, 2-bit encoded.
REQ-017 IDLE: if any reqN_valid, grant one port, assert its reqN_ready combinationally that cycle, latch A/B/ctrl and grant id, go to EXEC; else stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: single requester wins; on a tie the priority port wins, and priority moves to the other port after every grant.
REQ-019 reqN_ready SHALL be asserted only in IDLE, only for the granted port, and for exactly one cycle per grant.
REQ-020 EXEC: alu_A/alu_B/alu_ctrl SHALL drive the latched values; at cycle end, alu_result and alu_zero are captured into resp_result/resp_zero; go to RESP.
REQ-021 Outside EXEC, alu_A, alu_B and alu_ctrl SHALL still drive the latched values (no glitching to zero).
REQ-022 RESP: respN_valid SHALL be high only for the granted port; resp_result and resp_zero SHALL hold stable until the handshake.
REQ-023 In RESP, respN_valid && respN_ready SHALL complete the transfer and return to IDLE the next cycle; otherwise RESP is held indefinitely.
REQ-024 The respN_ready of the non-granted port SHALL be ignored.
REQ-025 Latency: grant in cycle T, respN_valid first high in cycle T+2; minimum issue interval 3 cycles.
REQ-026 Operation codes 100-111 SHALL be forwarded unchanged; this block performs no decoding.
REQ-027 A requester dropping reqN_valid before its grant SHALL lose nothing; no state is recorded for ungranted requests.
REQ-028 reqN_valid during EXEC/RESP SHALL be ignored (ready low); it is arbitrated on return to IDLE.

Reset
REQ-029 With reset low at a clk edge: state=IDLE, priority=RR_INIT, latched A/B/ctrl=0, resp_result=0, resp_zero=0.
REQ-030 Outputs during and after reset: all ready/valid outputs low; alu_A=alu_B=0; alu_ctrl=000.
REQ-031 Reset asserted in EXEC or RESP SHALL abort the operation with no response delivered; priority returns to RR_INIT.

Verification
REQ-032 Single request: req0 A=5, B=3, ctrl=010 at T -> req0_ready at T; resp0_valid at T+2 with result=8, zero=0.
REQ-033 Tie: both valid with RR_INIT=0; req0 ctrl=011, A=B=7; req1 ctrl=001, A=1, B=2 -> port 0 served first (result 0, zero=1), then port 1 (result 3), with no idle gap other than the FSM latency.
REQ-034 Back-pressure: resp1_ready low for 10 cycles -> resp1_valid and resp_result stay constant; req0 is not granted until one cycle after the resp1 handshake.
REQ-035 Wrong-port ready: in RESP for port 0, assert only resp1_ready -> FSM stays in RESP.
REQ-036 Mid-operation reset: assert reset in EXEC -> next cycle all valids/readys low, resp_result=0, priority=RR_INIT.
REQ-037 Unused opcode: ctrl=110, A=B=FFFFFFFF -> alu_ctrl=110 in EXEC; response delivers the ALU output (0) and zero=1.
